// File: rtl/alu_exec.sv
// alu_exec: 16-bit execute unit with a valid/ready handshake on each side.
// Logic ops and add/sub finish in one cycle. Shifts move SHIFT_STEP bits per
// BUSY cycle. MUL is an optional 16-cycle unsigned shift-add multiplier.
// Build option: define ALU_EXEC_MUL_EN to include the multiplier. Without it,
// op 111 completes in one cycle with result 0 and flag_z set.
module alu_exec #(
    parameter int SHIFT_STEP = 1    // bits shifted per BUSY cycle: 1, 2 or 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_c,
    output logic        flag_v
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SRA = 3'b110;
`ifdef ALU_EXEC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b111;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [2:0]  op_reg, op_next;
    logic [15:0] work_reg, work_next;      // partially shifted operand
    logic [4:0]  cnt_reg, cnt_next;        // remaining shift bits or MUL iterations
    logic [15:0] result_reg, result_next;
    logic        flag_z_reg, flag_z_next;
    logic        flag_n_reg, flag_n_next;
    logic        flag_c_reg, flag_c_next;
    logic        flag_v_reg, flag_v_next;

`ifdef ALU_EXEC_MUL_EN
    logic [31:0] mcand_reg, mcand_next;    // multiplicand, shifted left each step
    logic [15:0] mplier_reg, mplier_next;  // multiplier, shifted right each step
    logic [31:0] prod_reg, prod_next;      // running partial product
`endif

    // Values written into result/flags on the edge that enters DONE
    logic        load_result;
    logic [15:0] res_calc;
    logic        c_calc;
    logic        v_calc;
    logic [16:0] sum17;

    // Shift stage: one candidate per possible step size, selected by step_amt.
    // The last step is clipped so the total never exceeds the requested amount.
    logic [4:0]  step_amt;
    logic [15:0] shl_cand  [SHIFT_STEP:1];
    logic [15:0] sra_cand  [SHIFT_STEP:1];
    logic        cout_cand [SHIFT_STEP:1];
    logic [15:0] shl_sel;
    logic [15:0] sra_sel;
    logic        shl_out;

    assign step_amt = (cnt_reg < 5'(SHIFT_STEP)) ? cnt_reg : 5'(SHIFT_STEP);

    generate
        for (genvar gi = 1; gi <= SHIFT_STEP; gi++) begin : g_shift
            assign shl_cand[gi]  = work_reg << gi;
            assign sra_cand[gi]  = 16'($signed(work_reg) >>> gi);
            assign cout_cand[gi] = work_reg[16-gi];  // last bit pushed out by SHL
        end
    endgenerate

    // Pick the shift candidate that matches this cycle's step size
    always_comb begin
        shl_sel = work_reg;
        sra_sel = work_reg;
        shl_out = 1'b0;
        for (int i = 1; i <= SHIFT_STEP; i++) begin
            if (step_amt == 5'(i)) begin
                shl_sel = shl_cand[i];
                sra_sel = sra_cand[i];
                shl_out = cout_cand[i];
            end
        end
    end

    // Next-state, datapath next values and handshake outputs
    always_comb begin
        state_next  = state_reg;
        op_next     = op_reg;
        work_next   = work_reg;
        cnt_next    = cnt_reg;
        result_next = result_reg;
        flag_z_next = flag_z_reg;
        flag_n_next = flag_n_reg;
        flag_c_next = flag_c_reg;
        flag_v_next = flag_v_reg;
`ifdef ALU_EXEC_MUL_EN
        mcand_next  = mcand_reg;
        mplier_next = mplier_reg;
        prod_next   = prod_reg;
`endif
        load_result = 1'b0;
        res_calc    = 16'h0000;
        c_calc      = 1'b0;
        v_calc      = 1'b0;
        sum17       = 17'h00000;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    op_next = op;
                    case (op)
                        OP_ADD: begin
                            sum17       = {1'b0, a} + {1'b0, b};
                            res_calc    = sum17[15:0];
                            c_calc      = sum17[16];
                            v_calc      = (a[15] == b[15]) && (sum17[15] != a[15]);
                            load_result = 1'b1;
                            state_next  = DONE;
                        end
                        OP_SUB: begin
                            // carry = 1 means no borrow
                            sum17       = {1'b0, a} + {1'b0, ~b} + 17'd1;
                            res_calc    = sum17[15:0];
                            c_calc      = sum17[16];
                            v_calc      = (a[15] != b[15]) && (sum17[15] != a[15]);
                            load_result = 1'b1;
                            state_next  = DONE;
                        end
                        OP_AND: begin
                            res_calc    = a & b;
                            load_result = 1'b1;
                            state_next  = DONE;
                        end
                        OP_OR: begin
                            res_calc    = a | b;
                            load_result = 1'b1;
                            state_next  = DONE;
                        end
                        OP_XOR: begin
                            res_calc    = a ^ b;
                            load_result = 1'b1;
                            state_next  = DONE;
                        end
                        OP_SHL, OP_SRA: begin
                            if (b[3:0] == 4'd0) begin
                                res_calc    = a;
                                load_result = 1'b1;
                                state_next  = DONE;
                            end else begin
                                work_next  = a;
                                cnt_next   = {1'b0, b[3:0]};
                                state_next = BUSY;
                            end
                        end
                        default: begin
`ifdef ALU_EXEC_MUL_EN
                            mcand_next  = {16'h0000, a};
                            mplier_next = b;
                            prod_next   = 32'h0000_0000;
                            cnt_next    = 5'd16;
                            state_next  = BUSY;
`else
                            res_calc    = 16'h0000;
                            load_result = 1'b1;
                            state_next  = DONE;
`endif
                        end
                    endcase
                end
            end
            BUSY: begin
`ifdef ALU_EXEC_MUL_EN
                if (op_reg == OP_MUL) begin
                    if (mplier_reg[0]) begin
                        prod_next = prod_reg + mcand_reg;
                    end
                    mcand_next  = {mcand_reg[30:0], 1'b0};
                    mplier_next = {1'b0, mplier_reg[15:1]};
                    cnt_next    = cnt_reg - 5'd1;
                    if (cnt_reg == 5'd1) begin
                        res_calc    = prod_next[15:0];
                        c_calc      = |prod_next[31:16];
                        load_result = 1'b1;
                        state_next  = DONE;
                    end
                end else
`endif
                begin
                    work_next = (op_reg == OP_SHL) ? shl_sel : sra_sel;
                    cnt_next  = cnt_reg - step_amt;
                    if (cnt_next == 5'd0) begin
                        res_calc    = work_next;
                        c_calc      = (op_reg == OP_SHL) ? shl_out : 1'b0;
                        load_result = 1'b1;
                        state_next  = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load_result) begin
            result_next = res_calc;
            flag_z_next = (res_calc == 16'h0000);
            flag_n_next = res_calc[15];
            flag_c_next = c_calc;
            flag_v_next = v_calc;
        end
    end

    // FSM state register; reset aborts any operation in flight
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Captured operands, iteration state and the registered result/flags
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            op_reg     <= 3'b000;
            work_reg   <= 16'h0000;
            cnt_reg    <= 5'd0;
            result_reg <= 16'h0000;
            flag_z_reg <= 1'b0;
            flag_n_reg <= 1'b0;
            flag_c_reg <= 1'b0;
            flag_v_reg <= 1'b0;
        end else begin
            op_reg     <= op_next;
            work_reg   <= work_next;
            cnt_reg    <= cnt_next;
            result_reg <= result_next;
            flag_z_reg <= flag_z_next;
            flag_n_reg <= flag_n_next;
            flag_c_reg <= flag_c_next;
            flag_v_reg <= flag_v_next;
        end
    end

`ifdef ALU_EXEC_MUL_EN
    // Shift-add multiplier registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mcand_reg  <= 32'h0000_0000;
            mplier_reg <= 16'h0000;
            prod_reg   <= 32'h0000_0000;
        end else begin
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            prod_reg   <= prod_next;
        end
    end
`endif

    assign result = result_reg;
    assign flag_z = flag_z_reg;
    assign flag_n = flag_n_reg;
    assign flag_c = flag_c_reg;
    assign flag_v = flag_v_reg;

endmodule

// File: tb/tb_alu_exec.sv
// Testbench for alu_exec: directed corner cases followed by random operations.
// Each result is checked against a plain-arithmetic reference model.
module tb_alu_exec;

    localparam int STEP = 2;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'b000;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result;
    logic        flag_z, flag_n, flag_c, flag_v;

    int vectors     = 0;
    int miscompares = 0;
    int txn         = 0;

    always #5 CLK = ~CLK;

    alu_exec #(.SHIFT_STEP(STEP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    typedef struct {
        logic [15:0] r;
        logic [3:0]  f;    // {z, n, c, v}
        int          lat;  // rising edges from acceptance to out_valid
    } exp_t;

    // Reference model: expected result, flags and latency from the op rules
    function automatic exp_t model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
        exp_t        e;
        int          sx, sy, s, amt;
        logic [31:0] w;
        logic        c, v;
        sx    = int'($signed(x));
        sy    = int'($signed(y));
        amt   = int'(y[3:0]);
        e.r   = 16'h0000;
        e.lat = 1;
        c     = 1'b0;
        v     = 1'b0;
        case (o)
            3'd0: begin
                w   = 32'(x) + 32'(y);
                e.r = w[15:0];
                c   = w[16];
                s   = sx + sy;
                v   = (s > 32767) || (s < -32768);
            end
            3'd1: begin
                e.r = x - y;
                c   = (x >= y);
                s   = sx - sy;
                v   = (s > 32767) || (s < -32768);
            end
            3'd2: e.r = x & y;
            3'd3: e.r = x | y;
            3'd4: e.r = x ^ y;
            3'd5: begin
                w     = 32'(x) << amt;
                e.r   = w[15:0];
                c     = w[16];
                e.lat = 1 + (amt + STEP - 1) / STEP;
            end
            3'd6: begin
                e.r   = 16'($signed(x) >>> amt);
                e.lat = 1 + (amt + STEP - 1) / STEP;
            end
            default: begin
`ifdef ALU_EXEC_MUL_EN
                w     = 32'(x) * 32'(y);
                e.r   = w[15:0];
                c     = (w[31:16] != 16'h0000);
                e.lat = 17;
`else
                e.r   = 16'h0000;
`endif
            end
        endcase
        e.f = {(e.r == 16'h0000), e.r[15], c, v};
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One full transaction: accept, wait for DONE, hold, release
    task automatic do_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y, input int hold);
        exp_t        e;
        int          cycles;
        logic [15:0] r_seen;
        logic [3:0]  f_seen;
        e = model(o, x, y);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        op       = o;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        cycles = 1;
        while (out_valid !== 1'b1 && cycles < 100) begin
            check("in_ready_busy", 32'(in_ready), 32'd0);
            // later input changes and in_valid while busy must be ignored
            op       = 3'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'($urandom);
            @(posedge CLK);
            #1;
            cycles++;
        end
        check("latency", 32'(cycles), 32'(e.lat));
        check("result", 32'(result), 32'(e.r));
        check("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(e.f));
        r_seen = result;
        f_seen = {flag_z, flag_n, flag_c, flag_v};
        for (int h = 0; h < hold; h++) begin
            op       = 3'($urandom);
            a        = 16'($urandom);
            b        = 16'($urandom);
            in_valid = 1'($urandom);
            @(posedge CLK);
            #1;
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(e.r));
            check("hold_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(e.f));
        end
        // release with in_valid high: no acceptance may happen on this edge
        out_ready = 1'b1;
        in_valid  = 1'b1;
        op        = 3'($urandom);
        @(posedge CLK);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_out_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        txn++;
        $display("txn %0d op=%0d a=%h b=%h result=%h zncv=%b cycles=%0d", txn, o, x, y, r_seen, f_seen, cycles);
    endtask

    initial begin
        // reset state before any clock edge
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;

        // directed cases
        do_op(3'd0, 16'h7FFF, 16'h0001, 0);   // ADD signed overflow
        do_op(3'd1, 16'h0005, 16'hFFFB, 1);   // SUB 5 - (-5)
        do_op(3'd1, 16'h1234, 16'h1234, 0);   // SUB to zero
        do_op(3'd0, 16'hFFFF, 16'h0001, 0);   // ADD carry out, zero
        do_op(3'd6, 16'h8000, 16'h0005, 0);   // SRA 5 with step 2
        do_op(3'd7, 16'h0100, 16'h0100, 0);   // MUL (or disabled op 111)
        do_op(3'd0, 16'h1111, 16'h2222, 5);   // long hold in DONE
        do_op(3'd5, 16'h8001, 16'h0001, 0);   // SHL 1, carry out
        do_op(3'd5, 16'h0003, 16'hFF0F, 0);   // SHL 15, upper b bits ignored
        do_op(3'd6, 16'h1234, 16'hFFF0, 0);   // SRA amount 0
        do_op(3'd5, 16'hABCD, 16'h0010, 0);   // SHL amount 0
        do_op(3'd6, 16'h7FFF, 16'h000F, 0);   // SRA 15 positive -> 0
        do_op(3'd7, 16'hFFFF, 16'hFFFF, 0);
        do_op(3'd0, 16'h7FFF, 16'h0001, 0);   // leaves a nonzero result

        // asynchronous reset in the middle of a multi-cycle op
`ifdef ALU_EXEC_MUL_EN
        op = 3'd7;
        b  = 16'h0100;
`else
        op = 3'd5;
        b  = 16'h000F;
`endif
        a        = 16'h0100;
        in_valid = 1'b1;
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge CLK);
        #1;
        check("abort_busy_out_valid", 32'(out_valid), 32'd0);
        #2;
        RST = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_result", 32'(result), 32'd0);
        check("abort_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        #10;
        @(negedge CLK);
        RST = 1'b0;
        do_op(3'd0, 16'h0102, 16'h0304, 0);

        // random operations
        for (int i = 0; i < 60; i++) begin
            do_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), $urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global time bound so the run always terminates
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
